// File: rtl/multiplier_signed4.sv
// 4x4 signed multiplier: Baugh-Wooley partial-product array reduced by explicit
// half/full-adder cells, followed by a single output register (1-cycle latency).

module multiplier_signed4_ha (
  input  logic x,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ z;
  assign c = x & z;
endmodule

module multiplier_signed4_fa (
  input  logic x,
  input  logic z,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ z ^ ci;
  assign co = (x & z) | (ci & (x ^ z));
endmodule

// 8-bit ripple adder built from cells. The sum is modulo 2^8, so bit 7 needs no carry out.
module multiplier_signed4_add8 (
  input  logic [7:0] x,
  input  logic [7:0] z,
  output logic [7:0] s
);
  logic [6:0] c;

  multiplier_signed4_ha u_ha (
    .x (x[0]),
    .z (z[0]),
    .s (s[0]),
    .c (c[0])
  );

  for (genvar k = 1; k < 7; k++) begin : g_fa
    multiplier_signed4_fa u_fa (
      .x  (x[k]),
      .z  (z[k]),
      .ci (c[k-1]),
      .s  (s[k]),
      .co (c[k])
    );
  end

  assign s[7] = x[7] ^ z[7] ^ c[6];
endmodule

// Handshake: in_valid is a qualifier with no backpressure. A pair sampled with
// in_valid=1 appears on y one edge later with out_valid=1; with in_valid=0, y
// holds and out_valid drops.
module multiplier_signed4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  output logic [7:0] y,
  output logic       out_valid
);
  logic [7:0] row [4];
  logic [7:0] acc0;
  logic [7:0] acc1;
  logic [7:0] acc2;
  logic [7:0] prod;
  logic [7:0] y_d;
  logic [7:0] y_q;
  logic       out_valid_d;
  logic       out_valid_q;

  // Row j holds a[i]&b[j] at weight i+j; a term mixing one sign bit with one
  // magnitude bit is inverted (NAND).
  always_comb begin
    row = '{default: '0};
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        row[j][i+j] = (a[i] & b[j]) ^ ((i == 3) != (j == 3));
      end
    end
  end

  // Row 0 only occupies bits 0..3, so the +2^4 and +2^7 corrections merge in for free.
  assign acc0 = row[0] | 8'h90;

  multiplier_signed4_add8 u_add1 (.x(acc0), .z(row[1]), .s(acc1));
  multiplier_signed4_add8 u_add2 (.x(acc1), .z(row[2]), .s(acc2));
  multiplier_signed4_add8 u_add3 (.x(acc2), .z(row[3]), .s(prod));

  always_comb begin
    y_d         = y_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d = prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_multiplier_signed4.sv
// Bench for multiplier_signed4: directed corners, exhaustive sweep, random
// traffic, hold and asynchronous reset, checked against an integer reference model.

module tb_multiplier_signed4;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [7:0] y;
  logic       out_valid;

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];
  logic       expv_q[$];
  logic [7:0] model_y;

  multiplier_signed4 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_mul(input logic [3:0] xa, input logic [3:0] xb);
    int sa;
    int sb;
    int p;
    sa = xa[3] ? int'(xa) - 16 : int'(xa);
    sb = xb[3] ? int'(xb) - 16 : int'(xb);
    p  = sa * sb;
    return 8'(p);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: present one operand pair for one edge, then score the registered result.
  task automatic step(input logic [3:0] xa, input logic [3:0] xb, input logic v);
    logic [7:0] e;
    logic       ev;
    @(negedge clk);
    a        = xa;
    b        = xb;
    in_valid = v;
    if (v) model_y = ref_mul(xa, xb);
    exp_q.push_back(model_y);
    expv_q.push_back(v);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ev = expv_q.pop_front();
    check("y", y, e);
    check("out_valid", {7'b0, out_valid}, {7'b0, ev});
  endtask

  task automatic step_chk(input string tag, input logic [3:0] xa, input logic [3:0] xb,
                          input logic [7:0] lit);
    step(xa, xb, 1'b1);
    check(tag, y, lit);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    model_y  = 8'h00;
    rst      = 1'b1;
    a        = 4'h0;
    b        = 4'h0;
    in_valid = 1'b0;

    #2;
    check("reset_y", y, 8'h00);
    check("reset_out_valid", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // sign-sign and mixed corners, back to back
    step_chk("neg8_neg8", 4'b1000, 4'b1000, 8'h40);
    step_chk("neg4_neg7", 4'b1100, 4'b1001, 8'h1C);
    step_chk("neg7_neg6", 4'b1001, 4'b1010, 8'h2A);
    step_chk("neg1_neg1", 4'b1111, 4'b1111, 8'h01);
    step_chk("pos7_neg8", 4'b0111, 4'b1000, 8'hC8);
    step_chk("pos3_neg2", 4'b0011, 4'b1110, 8'hFA);
    step_chk("neg8_pos7", 4'b1000, 4'b0111, 8'hC8);
    step_chk("pos7_pos7", 4'b0111, 4'b0111, 8'h31);
    step_chk("neg5_zero", 4'b1011, 4'b0000, 8'h00);
    step_chk("zero_pos6", 4'b0000, 4'b0110, 8'h00);

    // exhaustive sweep with in_valid held high
    for (int i = 0; i < 256; i++) begin
      step(4'(i >> 4), 4'(i), 1'b1);
    end

    // hold: y keeps 7*7 while operands wander with in_valid low
    step_chk("load_7x7", 4'b0111, 4'b0111, 8'h31);
    step(4'b1000, 4'b1000, 1'b0);
    check("hold_y", y, 8'h31);
    step(4'bxxxx, 4'bxxxx, 1'b0);
    check("hold_y_x", y, 8'h31);

    // randomized traffic with bubbles
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset between edges, result discarded
    step_chk("preload_7x7", 4'b0111, 4'b0111, 8'h31);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_y", y, 8'h00);
    check("async_rst_out_valid", {7'b0, out_valid}, 8'h00);
    @(negedge clk);
    rst     = 1'b0;
    model_y = 8'h00;
    step_chk("post_rst_neg1_pos2", 4'b1111, 4'b0010, 8'hFE);
    step(4'b0101, 4'b1101, 1'b0);
    check("post_rst_hold", y, 8'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
